// File: rtl/quadrature_position_counter.sv
// quadrature_position_counter
// Decodes a mechanical quadrature rotary encoder (channels A/B) into a
// debounced, saturating position value. Also emits one-cycle Up, Down and
// Error pulses. Size and Signed must match the downstream display driver.
module quadrature_position_counter #(
  parameter int    Size           = 4,
  parameter string Signed         = "Yes",
  parameter int    DebounceCycles = 10000,
  parameter int    StepsPerDetent = 4
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            A,
  input  logic            B,
  input  logic            Clear,
  output logic [Size-1:0] Data,
  output logic            Up,
  output logic            Down,
  output logic            Error
);

  localparam bit IS_SIGNED = (Signed == "Yes");
  localparam int CNT_W     = (DebounceCycles > 1) ? $clog2(DebounceCycles) : 1;

  // Last count value before a pending change is accepted.
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DebounceCycles - 1);

  localparam logic signed [3:0] SPD_POS = 4'(StepsPerDetent);
  localparam logic signed [3:0] SPD_NEG = -SPD_POS;

  localparam logic [Size-1:0] DATA_MAX = IS_SIGNED ? {1'b0, {(Size-1){1'b1}}} : {Size{1'b1}};
  localparam logic [Size-1:0] DATA_MIN = IS_SIGNED ? {1'b1, {(Size-1){1'b0}}} : {Size{1'b0}};

  // Reject illegal parameterisations at elaboration time.
  if (!(StepsPerDetent == 1 || StepsPerDetent == 2 || StepsPerDetent == 4)) begin : g_bad_steps
    $error("quadrature_position_counter: StepsPerDetent must be 1, 2 or 4");
  end
  if (!(Signed == "Yes" || Signed == "No")) begin : g_bad_signed
    $error("quadrature_position_counter: Signed must be \"Yes\" or \"No\"");
  end
  if (DebounceCycles < 1) begin : g_bad_debounce
    $error("quadrature_position_counter: DebounceCycles must be at least 1");
  end

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  // Channel bit order everywhere is {A, B}.
  logic [1:0]            sync1_q, sync1_d;
  logic [1:0]            sync2_q, sync2_d;
  logic [1:0]            filt_q, filt_d;
  logic [1:0][CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic [CNT_W-1:0]      init_cnt_q, init_cnt_d;
  state_e                state_q, state_d;
  logic [1:0]            prev_q, prev_d;
  logic signed [3:0]     acc_q, acc_d;
  logic [Size-1:0]       data_q, data_d;
  logic                  up_q, up_d;
  logic                  down_q, down_d;
  logic                  error_q, error_d;

  logic                  pins_settled;
  logic                  step_cw, step_ccw;
  logic                  inc_req, dec_req;
  logic signed [3:0]     acc_next;

  // Forward (+1) Gray sequence 00 -> 01 -> 11 -> 10 -> 00.
  function automatic logic [1:0] cw_next(input logic [1:0] s);
    case (s)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  // Nothing in flight: both sync stages and the filtered value agree.
  assign pins_settled = (sync1_q == sync2_q) && (sync2_q == filt_q);

  // Synchroniser and per-channel debounce filter.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    sync1_d  = {A, B};
    sync2_d  = sync1_q;
    filt_d   = filt_q;
    db_cnt_d = '0;
    for (int ch = 0; ch < 2; ch++) begin
      if (sync2_q[ch] != filt_q[ch]) begin
        if (db_cnt_q[ch] == DB_LAST) begin
          filt_d[ch] = sync2_q[ch];
        end else begin
          db_cnt_d[ch] = db_cnt_q[ch] + 1'b1;
        end
      end
    end
  end

  // Decoder FSM: wait for settled inputs, then classify each filtered transition.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    prev_d     = prev_q;
    step_cw    = 1'b0;
    step_ccw   = 1'b0;
    error_d    = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        if (pins_settled) begin
          if (init_cnt_q == DB_LAST) begin
            state_d    = ST_RUN;
            prev_d     = filt_q;
            init_cnt_d = '0;
          end else begin
            init_cnt_d = init_cnt_q + 1'b1;
          end
        end else begin
          init_cnt_d = '0;
        end
      end
      ST_RUN: begin
        prev_d = filt_q;
        if (filt_q != prev_q) begin
          if (filt_q == ~prev_q) begin
            error_d = 1'b1;
          end else if (filt_q == cw_next(prev_q)) begin
            step_cw = 1'b1;
          end else begin
            step_ccw = 1'b1;
          end
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Detent accumulator and saturating position update; Clear wins over a step.
  always_comb begin
    inc_req  = 1'b0;
    dec_req  = 1'b0;
    acc_next = acc_q;
    if (step_cw) begin
      acc_next = acc_q + 4'sd1;
    end else if (step_ccw) begin
      acc_next = acc_q - 4'sd1;
    end
    if (acc_next == SPD_POS) begin
      inc_req  = 1'b1;
      acc_next = '0;
    end else if (acc_next == SPD_NEG) begin
      dec_req  = 1'b1;
      acc_next = '0;
    end

    acc_d  = acc_next;
    data_d = data_q;
    up_d   = 1'b0;
    down_d = 1'b0;
    if (Clear) begin
      data_d = '0;
      acc_d  = '0;
    end else if (inc_req) begin
      if (data_q != DATA_MAX) begin
        data_d = data_q + 1'b1;
        up_d   = 1'b1;
      end
    end else if (dec_req) begin
      if (data_q != DATA_MIN) begin
        data_d = data_q - 1'b1;
        down_d = 1'b1;
      end
    end
  end

  // All state registers; Reset is synchronous and overrides every other input.
  always_ff @(posedge Clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (Reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      filt_q     <= '0;
      db_cnt_q   <= '0;
      init_cnt_q <= '0;
      state_q    <= ST_INIT;
      prev_q     <= '0;
      acc_q      <= '0;
      data_q     <= '0;
      up_q       <= 1'b0;
      down_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      filt_q     <= filt_d;
      db_cnt_q   <= db_cnt_d;
      init_cnt_q <= init_cnt_d;
      state_q    <= state_d;
      prev_q     <= prev_d;
      acc_q      <= acc_d;
      data_q     <= data_d;
      up_q       <= up_d;
      down_q     <= down_d;
      error_q    <= error_d;
    end
  end

  assign Data  = data_q;
  assign Up    = up_q;
  assign Down  = down_q;
  assign Error = error_q;

endmodule
